// File: rtl/rx_sseg_display.sv
// Shows the last two good bytes from a serial receiver on a 4-digit hex display, colon flags recent framing errors.
// Latency: display pins are registered, one cycle behind internal state; good_cnt updates on the accepting edge.
// Backpressure: none, every rx_valid strobe is consumed in its cycle.
module rx_sseg_display #(
    parameter int REFRESH_DIV = 50000,
    parameter int ERR_HOLD    = 25000000
) (
    input  logic       M_CLOCK,
    input  logic       M_RESET_N,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    input  logic       rx_ferr,
    input  logic       clr,
    output logic [7:0] IO_SSEG,
    output logic [3:0] IO_SSEGD,
    output logic       IO_SSEG_COL,
    output logic [7:0] good_cnt
);

    localparam int RW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam int EW = $clog2(ERR_HOLD + 1);
    localparam logic [RW-1:0] REF_MAX  = RW'(REFRESH_DIV - 1);
    localparam logic [EW-1:0] ERR_LOAD = EW'(ERR_HOLD);

    logic [15:0]   hist;
    logic [1:0]    fill;
    logic [EW-1:0] err_cnt;
    logic [RW-1:0] ref_cnt;
    logic [1:0]    dig_idx;

    logic [3:0]    nib;
    logic          dig_pop;
    logic [7:0]    sseg_nxt;
    logic [3:0]    ssegd_nxt;

    function automatic logic [6:0] hex7(input logic [3:0] v);
        case (v)
            4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
            4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
            4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
            4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
            4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
            4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
            4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
            4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
        endcase
    endfunction

    // Low digit pair needs one accepted byte, high pair needs two.
    always_comb begin
        nib     = 4'h0;
        dig_pop = 1'b0;
        case (dig_idx)
            2'd0:    begin nib = hist[3:0];   dig_pop = (fill != 2'd0); end
            2'd1:    begin nib = hist[7:4];   dig_pop = (fill != 2'd0); end
            2'd2:    begin nib = hist[11:8];  dig_pop = (fill == 2'd2); end
            default: begin nib = hist[15:12]; dig_pop = (fill == 2'd2); end
        endcase
        sseg_nxt  = dig_pop ? {1'b1, hex7(nib)} : 8'hFF;
        ssegd_nxt = dig_pop ? ~(4'b0001 << dig_idx) : 4'hF;
    end

    always_ff @(posedge M_CLOCK) begin
        if (!M_RESET_N) begin
            hist        <= '0;
            fill        <= '0;
            good_cnt    <= '0;
            err_cnt     <= '0;
            ref_cnt     <= '0;
            dig_idx     <= '0;
            IO_SSEG     <= 8'hFF;
            IO_SSEGD    <= 4'hF;
            IO_SSEG_COL <= 1'b1;
        end else begin
            if (ref_cnt == REF_MAX) begin
                ref_cnt <= '0;
                dig_idx <= dig_idx + 2'd1;
            end else begin
                ref_cnt <= ref_cnt + 1'b1;
            end

            if (rx_valid && rx_ferr)
                err_cnt <= ERR_LOAD;
            else if (err_cnt != '0)
                err_cnt <= err_cnt - 1'b1;

            // A clear wins over a byte arriving in the same cycle; that byte is lost.
            if (clr) begin
                hist <= '0;
                fill <= '0;
            end else if (rx_valid && !rx_ferr) begin
                hist     <= {hist[7:0], rx_data};
                good_cnt <= good_cnt + 8'd1;
                if (fill != 2'd2)
                    fill <= fill + 2'd1;
            end

            IO_SSEG     <= sseg_nxt;
            IO_SSEGD    <= ssegd_nxt;
            IO_SSEG_COL <= (err_cnt == '0);
        end
    end

endmodule
